// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - register map, status bit positions and serializer states for uart_tx_mmio
package uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_OVF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO that drops pushes arriving while full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the pre-edge count, so a simultaneous pop cannot rescue a push.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [1:0]  memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        txd
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic          hit;
    logic [1:0]    offset;
    logic          bus_wr;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic [15:0]   bauddiv;
    logic          busy;
    logic          unused_bits;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [15:0]   timer;
    logic [15:0]   reload;
    logic          bit_end;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign bus_wr      = (memwrite != 2'b00) && hit;
    assign push        = bus_wr && (offset == OFF_TXDATA);
    assign busy        = (state != IDLE);
    assign bit_end     = (timer == 16'd0);
    assign unused_bits = ^{addr[1:0], wd[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .din     (wd[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ovf     <= 1'b0;
            bauddiv <= DIV_RESET;
        end else begin
            if (push && (fifo_count == FULL_COUNT)) begin
                ovf <= 1'b1;
            end else if (bus_wr && (offset == OFF_STATUS) && wd[ST_OVF]) begin
                ovf <= 1'b0;
            end
            if (bus_wr && (offset == OFF_BAUDDIV)) begin
                bauddiv <= wd[15:0];
            end
        end
    end

    always_comb begin
        rd = 32'h0;
        if (hit) begin
            case (offset)
                OFF_STATUS: begin
                    rd[ST_OVF]   = ovf;
                    rd[ST_BUSY]  = busy;
                    rd[ST_EMPTY] = fifo_empty;
                    rd[ST_FULL]  = fifo_full;
                end
                OFF_BAUDDIV: rd[15:0] = bauddiv;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STOP chains straight into START when more data is queued, giving gapless frames.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The divisor is captured only when a frame is loaded, so mid-frame writes wait for the next frame.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shreg   <= 8'h00;
            bit_idx <= 3'd0;
            timer   <= 16'd0;
            reload  <= 16'd0;
            txd     <= 1'b1;
        end else if (pop) begin
            shreg  <= fifo_dout;
            reload <= bauddiv;
            timer  <= bauddiv;
            txd    <= 1'b0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                timer <= reload;
                case (state)
                    START: begin
                        txd     <= shreg[0];
                        bit_idx <= 3'd0;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end
                    default: txd <= 1'b1;
                endcase
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule
